multdiv: RTL
============

# multdiv

Sequential signed 32-bit multiply/divide unit for the simple processor, used beside the combinational add/sub ALU for `mul` and `div` instructions. Each operation takes one start pulse, runs for a fixed 33 cycles, and returns a 32-bit result with an exception flag. Completion is signalled with a single-cycle ready strobe. The pipeline stalls on `ctrl_MULT` or `ctrl_DIV` until `data_resultRDY`.

## Interface

- No parameters; width fixed at 32.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `data_operandA`  in  32  multiplicand / dividend, two's complement.
- `data_operandB`  in  32  multiplier / divisor, two's complement.
- `ctrl_MULT`  in  1  start-multiply pulse.
- `ctrl_DIV`  in  1  start-divide pulse.
- `data_result`  out  32  registered result.
- `data_exception`  out  1  registered exception flag, valid with the result.
- `data_resultRDY`  out  1  one-cycle completion strobe.

## Operation

- **Operand capture**
  - Operands are captured only on the edge where `ctrl_MULT` or `ctrl_DIV` is sampled high.
  - Operands may change freely afterwards.
- **States**
  - IDLE:
    - a sampled start pulse loads the operand registers, clears the 6-bit counter, and goes to MUL or DIV.
  - MUL / DIV:
    - 32 iteration cycles, counter 0..31.
    - When the counter reaches 31, go to FIN.
  - FIN:
    - one cycle of sign correction and exception evaluation.
    - registers `data_result` and `data_exception`, pulses `data_resultRDY`, returns to IDLE.
- **Multiply**
  - Radix-2 shift-add on operand magnitudes into a 64-bit product register.
  - Negate the product if the operand signs differ.
  - `data_result` = product[31:0].
  - `data_exception` = 1 when product[63:31] are not all equal, i.e. the product does not fit in signed 32 bits.
- **Divide**
  - Restoring division on magnitudes, quotient truncated toward zero, remainder discarded.
  - Quotient is negated if the operand signs differ.
  - Divisor 0:
    - `data_result` = 0, `data_exception` = 1.
    - Same 33-cycle latency; no early exit.
  - 0x80000000 / 0xFFFFFFFF: `data_result` = 0x80000000, `data_exception` = 1.
  - Magnitude of 0x80000000 is handled as unsigned 0x80000000 (33-bit internal working width).
- **Priority and boundary cases**
  - `ctrl_MULT` and `ctrl_DIV` both high on the same edge: treated as multiply.
  - Start pulse while in MUL, DIV or FIN: aborts the current operation, restarts with the new operands and op, and no RDY is produced for the aborted op.
    - Exception: a start sampled on the same edge that leaves FIN. The old op's RDY still fires, since RDY is registered from FIN, and the new op starts.
  - Start pulse held high for multiple cycles: every sampled-high edge restarts the operation. The driver must pulse for exactly one cycle.
  - `reset` high on any edge:
    - state goes to IDLE; `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
    - any in-flight op is discarded; reset overrides a simultaneous start.
- `data_result` and `data_exception` hold their value after RDY until the next FIN.

## Timing

- Start sampled at edge E0, meaning the pulse is high during cycle 0.
  - Iterations run at edges E1..E32.
  - FIN results register at E33.
  - `data_resultRDY` is high during cycle 33 only.
- Latency is 33 cycles for every op, including divide-by-zero.
- Reset values: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
- No combinational path from any input to any output.

## Test plan

- **Basic multiply:** MULT with A=7, B=0xFFFFFFFD (-3).
  - Expect `data_result` = 0xFFFFFFEB and `data_exception` = 0.
  - RDY high exactly in cycle 33 and low in cycles 32 and 34.
- **Multiply overflow:**
  - 0x00010000 × 0x00010000 → result 0x00000000, exception 1.
  - 0xFFFFFFFF × 0x80000000 → result 0x80000000, exception 1.
  - 0x80000000 × 1 → result 0x80000000, exception 0.
- **Signed divide:**
  - 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - 7 / 0xFFFFFFFE → 0xFFFFFFFD.
  - 100 / 7 → 14.
  - All with exception 0.
- **Divide exceptions:**
  - 5 / 0 → result 0, exception 1, RDY in cycle 33.
  - 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception 1.
- **Restart:**
  - MULT 3×4 at cycle 0, then DIV 100/7 pulsed at cycle 10.
  - No RDY at cycle 33; a single RDY at cycle 43 with result 14.
  - Also: start on the FIN edge gives the old RDY, followed by the new op's RDY 33 cycles later.
- **Reset mid-operation:**
  - MULT at cycle 0, then `reset` in cycle 20.
  - Outputs 0 from cycle 21; no RDY.
  - A following DIV 9/3 completes normally → 3, exception 0.

Source files
------------

// File: rtl/multdiv.sv
// Sequential signed 32-bit multiply/divide unit with a fixed 33-cycle latency.
// Shift-add multiply and restoring divide run on operand magnitudes; the sign is fixed up in FIN.
module multdiv (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY
);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIN
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        start;
   logic [5:0]  count;
   logic        op_div;
   logic        sign_neg;
   logic        div_zero;
   logic        div_ovf;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   logic [63:0] prod;
   logic [32:0] add_sum;

   logic [32:0] rem;
   logic [31:0] quo;
   logic [32:0] rem_shift;
   logic [32:0] rem_trial;
   logic        trial_fits;

   logic [63:0] prod_signed;
   logic [31:0] quo_signed;
   logic        mul_exc;
   logic [31:0] fin_result;
   logic        fin_exc;

   assign start = ctrl_MULT | ctrl_DIV;
   assign abs_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
   assign abs_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

   // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
   assign add_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);

   // One restoring step: the dividend bit enters the partial remainder; subtract if the divisor fits.
   assign rem_shift  = {rem[31:0], quo[31]};
   assign trial_fits = ({rem, quo[31]} >= {2'b00, mag_b});
   assign rem_trial  = rem_shift - {1'b0, mag_b};

   assign prod_signed = sign_neg ? (~prod + 64'd1) : prod;
   assign quo_signed  = sign_neg ? (~quo + 32'd1) : quo;
   assign mul_exc     = ~((&prod_signed[63:31]) | ~(|prod_signed[63:31]));

   always_comb begin
      fin_result = prod_signed[31:0];
      fin_exc    = mul_exc;
      if (op_div) begin
         if (div_zero) begin
            fin_result = 32'd0;
            fin_exc    = 1'b1;
         end else if (div_ovf) begin
            fin_result = 32'h8000_0000;
            fin_exc    = 1'b1;
         end else begin
            fin_result = quo_signed;
            fin_exc    = 1'b0;
         end
      end
   end

   // A sampled start wins in every state, so a new pulse always aborts and restarts.
   always_comb begin
      next_state = state;
      if (start) begin
         next_state = ctrl_MULT ? MUL : DIV;
      end else begin
         case (state)
            IDLE:    next_state = IDLE;
            MUL:     next_state = (count == 6'd31) ? FIN : MUL;
            DIV:     next_state = (count == 6'd31) ? FIN : DIV;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FIN always publishes its result, even when a new start is sampled on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= 6'd0;
         op_div         <= 1'b0;
         sign_neg       <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         mag_a          <= 32'd0;
         mag_b          <= 32'd0;
         prod           <= 64'd0;
         rem            <= 33'd0;
         quo            <= 32'd0;
         data_result    <= 32'd0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (state == FIN) begin
            data_result    <= fin_result;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
         end

         if (start) begin
            count    <= 6'd0;
            op_div   <= ~ctrl_MULT;
            sign_neg <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            mag_a    <= abs_a;
            mag_b    <= abs_b;
            prod     <= {32'd0, abs_b};
            rem      <= 33'd0;
            quo      <= abs_a;
         end else if (state == MUL) begin
            count <= count + 6'd1;
            prod  <= {add_sum, prod[31:1]};
         end else if (state == DIV) begin
            count <= count + 6'd1;
            rem   <= trial_fits ? rem_trial : rem_shift;
            quo   <= {quo[30:0], trial_fits};
         end
      end
   end

endmodule
